// File: rtl/spi_led_host.sv
// spi_led_host: SPI mode-0 host for the LED register peripheral.
// Runs one WIDTH-bit full-duplex transfer per explicit request, or auto-polls
// the peripheral when it raises read_needed and polling is enabled.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start, or for poll_en && read_needed
// SETUP | CS asserted, first MOSI bit presented, CLK_DIV cycles
// LOW   | spi_clk low, MOSI settling; MISO sampled on the last cycle
// HIGH  | spi_clk high; bit counter advances on exit
// HOLD  | spi_clk low after the last bit, CS still asserted
// GAP   | CS released, write_en still held so the peripheral commits
module spi_led_host #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             write,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             poll_en,
    input  logic             read_needed,
    output logic             busy,
    output logic             done,
    output logic             polled,
    output logic [WIDTH-1:0] rx_data,
    output logic             spi_csn,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_write_en
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] BITS_ALL = CNT_W'(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_inc;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] rx_sh;
    logic             poll_flag;
    logic             phase_end;

    // Every non-idle phase lasts CLK_DIV cycles; the down-counter hits zero on its last cycle.
    assign phase_end   = (div_cnt == '0);
    // Saturating increment so the counter can never wrap past WIDTH.
    assign bit_cnt_inc = (bit_cnt == BITS_ALL) ? bit_cnt : bit_cnt + 1'b1;

    // Transfer sequencer: phase timing, shift registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            poll_flag    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            polled       <= 1'b0;
            rx_data      <= '0;
            spi_csn      <= 1'b1;
            spi_clk      <= 1'b0;
            spi_mosi     <= 1'b0;
            spi_write_en <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                div_cnt <= phase_end ? DIV_LAST : div_cnt - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start || (poll_en && read_needed)) begin
                        state   <= SETUP;
                        div_cnt <= DIV_LAST;
                        bit_cnt <= '0;
                        rx_sh   <= '0;
                        busy    <= 1'b1;
                        spi_csn <= 1'b0;
                        // tx_sh holds the bits still to be presented after the current one.
                        if (start) begin
                            tx_sh        <= tx_data >> 1;
                            spi_mosi     <= tx_data[0];
                            spi_write_en <= write;
                            poll_flag    <= 1'b0;
                        end else begin
                            tx_sh        <= '0;
                            spi_mosi     <= 1'b0;
                            spi_write_en <= 1'b0;
                            poll_flag    <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (phase_end) state <= LOW;
                end
                LOW: begin
                    if (phase_end) begin
                        // Sample before the rising edge: the peripheral shifts on the edge it sees.
                        rx_sh   <= {rx_sh[WIDTH-2:0], spi_miso};
                        spi_clk <= 1'b1;
                        state   <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        spi_clk <= 1'b0;
                        bit_cnt <= bit_cnt_inc;
                        if (bit_cnt_inc < BITS_ALL) begin
                            spi_mosi <= tx_sh[0];
                            tx_sh    <= tx_sh >> 1;
                            state    <= LOW;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        spi_csn <= 1'b1;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    // The gap also lets read_needed settle low before IDLE looks at it again.
                    if (phase_end) begin
                        spi_write_en <= 1'b0;
                        done         <= 1'b1;
                        rx_data      <= rx_sh;
                        polled       <= poll_flag;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_led_host.sv
// Testbench for spi_led_host with a behavioural LED register peripheral.
module tb_spi_led_host;

    localparam int WIDTH   = 8;
    localparam int CLK_DIV = 2;
    localparam int LAT     = (2 * WIDTH + 3) * CLK_DIV;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             write = 1'b0;
    logic [WIDTH-1:0] tx_data = '0;
    logic             poll_en = 1'b0;
    logic             read_needed = 1'b0;
    logic             busy;
    logic             done;
    logic             polled;
    logic [WIDTH-1:0] rx_data;
    logic             spi_csn;
    logic             spi_clk;
    logic             spi_mosi;
    logic             spi_miso;
    logic             spi_write_en;

    int errors = 0;
    int checks = 0;

    // Peripheral state
    logic [WIDTH-1:0] p_led = '0;
    logic [WIDTH-1:0] p_send = '0;
    logic [WIDTH-1:0] p_recv = '0;
    logic             p_csn_q = 1'b1;
    logic             p_sclk_q = 1'b0;
    logic             inc_req = 1'b0;
    logic             led_set = 1'b0;
    logic [WIDTH-1:0] led_set_val = '0;
    bit               mosi_q[$];
    int               done_cnt = 0;

    always #5 clk = ~clk;

    spi_led_host #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .write(write), .tx_data(tx_data),
        .poll_en(poll_en), .read_needed(read_needed), .busy(busy), .done(done),
        .polled(polled), .rx_data(rx_data), .spi_csn(spi_csn), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_write_en(spi_write_en)
    );

    assign spi_miso = p_send[WIDTH-1];

    // LED register peripheral: loads send buffer at CS fall, shifts on detected
    // rising spi_clk, commits received word at CS rise if write_en is still high.
    always @(posedge clk) begin
        p_csn_q  <= spi_csn;
        p_sclk_q <= spi_clk;
        if (done) done_cnt <= done_cnt + 1;
        if (led_set) p_led <= led_set_val;
        else if (inc_req) begin
            p_led       <= p_led + 1'b1;
            read_needed <= 1'b1;
        end
        if (p_csn_q && !spi_csn) begin
            p_send      <= p_led;
            read_needed <= 1'b0;
        end else if (!spi_csn && spi_clk && !p_sclk_q) begin
            p_send <= p_send << 1;
            p_recv <= {spi_mosi, p_recv[WIDTH-1:1]};
            mosi_q.push_back(spi_mosi);
        end
        if (!p_csn_q && spi_csn && spi_write_en) p_led <= p_recv;
    end

    task automatic set_led(input logic [WIDTH-1:0] v);
        led_set     = 1'b1;
        led_set_val = v;
        @(negedge clk);
        led_set = 1'b0;
    endtask

    task automatic run_xfer(input logic wr, input logic [WIDTH-1:0] tx, output int lat,
                            output logic busy_first, output logic csn_first,
                            output logic [WIDTH-1:0] rx_mid);
        mosi_q.delete();
        start   = 1'b1;
        write   = wr;
        tx_data = tx;
        @(negedge clk);
        start      = 1'b0;
        write      = 1'b0;
        tx_data    = WIDTH'($urandom);
        lat        = 0;
        busy_first = busy;
        csn_first  = spi_csn;
        rx_mid     = rx_data;
        while (!done && lat < LAT + 50) begin
            @(negedge clk);
            lat++;
            if (lat == LAT / 2) rx_mid = rx_data;
        end
    endtask

    function automatic logic [WIDTH-1:0] mosi_word();
        logic [WIDTH-1:0] w = '0;
        for (int i = 0; i < WIDTH && i < mosi_q.size(); i++) w[i] = mosi_q[i];
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (spi_csn !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b expected 1", spi_csn); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", spi_clk); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_rx: got %h expected 00", rx_data); end
        checks++; if ({spi_mosi, spi_write_en, done, polled} !== 4'b0) begin
            errors++; $display("FAIL reset_misc: got %b expected 0000", {spi_mosi, spi_write_en, done, polled});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        int lat; logic bf, cf; logic [WIDTH-1:0] mid;
        set_led(8'hA5);
        run_xfer(1'b0, 8'h00, lat, bf, cf, mid);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL read_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (bf !== 1'b1 || cf !== 1'b0) begin errors++; $display("FAIL read_launch: busy=%b csn=%b expected busy=1 csn=0", bf, cf); end
        checks++; if (mid !== 8'h00) begin errors++; $display("FAIL read_rx_hold: got %h expected 00", mid); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL read_rx: got %h expected a5", rx_data); end
        checks++; if (polled !== 1'b0) begin errors++; $display("FAIL read_polled: got %b expected 0", polled); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL read_after: done=%b busy=%b expected 0 0", done, busy); end
        checks++; if (p_led !== 8'hA5) begin errors++; $display("FAIL read_led: got %h expected a5", p_led); end
    endtask

    task automatic test_write();
        int lat; logic bf, cf; logic [WIDTH-1:0] mid;
        set_led(8'h5A);
        run_xfer(1'b1, 8'h3C, lat, bf, cf, mid);
        checks++; if (mosi_q.size() != WIDTH || mosi_word() !== 8'h3C) begin
            errors++; $display("FAIL write_mosi: got %h (%0d bits) expected 3c (8 bits)", mosi_word(), mosi_q.size());
        end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL write_rx: got %h expected 5a", rx_data); end
        @(negedge clk);
        checks++; if (p_led !== 8'h3C) begin errors++; $display("FAIL write_led: got %h expected 3c", p_led); end
    endtask

    task automatic test_random();
        int lat; logic bf, cf; logic [WIDTH-1:0] mid, led0, tx, exp_led;
        logic wr;
        for (int i = 0; i < 10; i++) begin
            led0 = WIDTH'($urandom);
            tx   = WIDTH'($urandom);
            wr   = 1'($urandom);
            exp_led = wr ? tx : led0;
            set_led(led0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_xfer(wr, tx, lat, bf, cf, mid);
            checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            checks++; if (rx_data !== led0) begin errors++; $display("FAIL rand_rx[%0d]: got %h expected %h", i, rx_data, led0); end
            checks++; if (mosi_word() !== tx) begin errors++; $display("FAIL rand_mosi[%0d]: got %h expected %h", i, mosi_word(), tx); end
            @(negedge clk);
            checks++; if (p_led !== exp_led) begin errors++; $display("FAIL rand_led[%0d]: got %h expected %h", i, p_led, exp_led); end
        end
    endtask

    task automatic test_poll();
        int n; int base;
        poll_en = 1'b0;
        set_led(8'h07);
        base    = done_cnt;
        poll_en = 1'b1;
        inc_req = 1'b1;
        @(negedge clk);
        inc_req = 1'b0;
        n = 0;
        while (!done && n < LAT + 50) begin @(negedge clk); n++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL poll_done: got %b expected 1 within %0d cycles", done, LAT + 50); end
        checks++; if (rx_data !== 8'h08) begin errors++; $display("FAIL poll_rx: got %h expected 08", rx_data); end
        checks++; if (polled !== 1'b1) begin errors++; $display("FAIL poll_flag: got %b expected 1", polled); end
        repeat (150) @(negedge clk);
        checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL poll_once: got %0d transfers expected 1", done_cnt - base); end
        checks++; if (p_led !== 8'h08) begin errors++; $display("FAIL poll_led: got %h expected 08", p_led); end
        poll_en = 1'b0;
    endtask

    task automatic test_start_vs_poll();
        int lat, base; logic bf, cf; logic [WIDTH-1:0] mid, led0, tx;
        led0 = WIDTH'($urandom);
        tx   = WIDTH'($urandom);
        set_led(led0);
        base    = done_cnt;
        inc_req = 1'b1;
        @(negedge clk);
        inc_req = 1'b0;
        poll_en = 1'b1;
        run_xfer(1'b1, tx, lat, bf, cf, mid);
        checks++; if (polled !== 1'b0) begin errors++; $display("FAIL prio_polled: got %b expected 0", polled); end
        checks++; if (rx_data !== led0 + 8'd1) begin errors++; $display("FAIL prio_rx: got %h expected %h", rx_data, led0 + 8'd1); end
        repeat (150) @(negedge clk);
        checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL prio_count: got %0d transfers expected 1", done_cnt - base); end
        checks++; if (p_led !== tx) begin errors++; $display("FAIL prio_led: got %h expected %h", p_led, tx); end
        poll_en = 1'b0;
    endtask

    task automatic test_ignore_start();
        int n, rises, base; logic prev; logic [WIDTH-1:0] led0;
        led0 = WIDTH'($urandom);
        set_led(led0);
        base  = done_cnt;
        start = 1'b1; write = 1'b0; tx_data = '0;
        @(negedge clk);
        start = 1'b0;
        n = 0; rises = 0; prev = spi_clk;
        while (rises < 4 && n < LAT + 50) begin
            @(negedge clk); n++;
            if (spi_clk && !prev) rises++;
            prev = spi_clk;
        end
        checks++; if (spi_clk !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL ignore_phase: sclk=%b busy=%b expected 1 1 at bit 3", spi_clk, busy);
        end
        start = 1'b1; write = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        start = 1'b0; write = 1'b0;
        n = 0;
        while (!done && n < LAT + 50) begin @(negedge clk); n++; end
        checks++; if (rx_data !== led0 || done !== 1'b1) begin
            errors++; $display("FAIL ignore_rx: got %h done=%b expected %h done=1", rx_data, done, led0);
        end
        repeat (150) @(negedge clk);
        checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL ignore_count: got %0d transfers expected 1", done_cnt - base); end
        checks++; if (p_led !== led0) begin errors++; $display("FAIL ignore_led: got %h expected %h", p_led, led0); end
    endtask

    task automatic test_reset_mid();
        int n, rises, base, lat; logic prev, bf, cf; logic [WIDTH-1:0] led0, mid;
        led0 = WIDTH'($urandom);
        set_led(led0);
        base  = done_cnt;
        start = 1'b1; write = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        start = 1'b0; write = 1'b0;
        n = 0; rises = 0; prev = spi_clk;
        while (rises < 6 && n < LAT + 50) begin
            @(negedge clk); n++;
            if (spi_clk && !prev) rises++;
            prev = spi_clk;
        end
        checks++; if (spi_write_en !== 1'b1 || spi_csn !== 1'b0) begin
            errors++; $display("FAIL rstmid_pre: we=%b csn=%b expected 1 0 at bit 5", spi_write_en, spi_csn);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (spi_csn !== 1'b1 || spi_write_en !== 1'b0) begin
            errors++; $display("FAIL rstmid_pins: csn=%b we=%b expected 1 0", spi_csn, spi_write_en);
        end
        checks++; if (busy !== 1'b0 || spi_clk !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: busy=%b sclk=%b done=%b expected 0 0 0", busy, spi_clk, done);
        end
        reset = 1'b0;
        repeat (100) @(negedge clk);
        checks++; if (done_cnt !== base) begin errors++; $display("FAIL rstmid_nodone: got %0d done pulses expected 0", done_cnt - base); end
        checks++; if (p_led !== led0) begin errors++; $display("FAIL rstmid_led: got %h expected %h", p_led, led0); end
        run_xfer(1'b0, 8'h00, lat, bf, cf, mid);
        checks++; if (rx_data !== led0) begin errors++; $display("FAIL rstmid_read: got %h expected %h", rx_data, led0); end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_read();
        test_write();
        test_random();
        test_poll();
        test_start_vs_poll();
        test_ignore_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
